// File: rtl/iic_slave_if.sv
// I2C line bundle between a bus master (or bench) and the iic_slave target.
// sda_i is the wired-AND line level; sda_o/sda_oen_n form the open-drain driver.
interface iic_slave_if;
    logic scl_i;
    logic sda_i;
    logic sda_o;
    logic sda_oen_n;

    modport slave  (input  scl_i, sda_i, output sda_o, sda_oen_n);
    modport master (output scl_i, sda_i, input  sda_o, sda_oen_n);
endinterface

// File: rtl/iic_slave.sv
// I2C target with a 16 x 8 register file: pointer write, data write with
// auto-increment, repeated-start reads, plus a local host read/write port.
module iic_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic             clk,
    input  logic             rst_n,
    iic_slave_if.slave       bus,
    input  logic [3:0]       loc_adr,
    input  logic             loc_we,
    input  logic [7:0]       loc_wdata,
    output logic [7:0]       loc_rdata,
    output logic             wr_stb,
    output logic [3:0]       wr_adr,
    output logic [7:0]       wr_data,
    output logic             busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
    } state_t;

    logic scl_s1, scl_s2, scl_prev;
    logic sda_s1, sda_s2, sda_prev;
    logic scl_rise, scl_fall, start_det, stop_det, sda_bit;

    state_t     state, state_n;
    logic [7:0] shift, shift_n;
    logic [3:0] bit_cnt, bit_cnt_n;
    logic [3:0] ptr, ptr_n;
    logic       oen_q, oen_n;
    logic       busy_q, busy_n;
    logic       wr_stb_n;
    logic [3:0] wr_adr_n;
    logic [7:0] wr_data_n;
    logic       bus_we;
    logic [7:0] byte_in;
    logic [3:0] ptr_inc;
    logic [7:0] regfile [16];

    // Synchronizers reset to the idle-high line level so release from reset
    // never looks like a START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1    <= 1'b1;
            scl_s2    <= 1'b1;
            scl_prev  <= 1'b1;
            sda_s1    <= 1'b1;
            sda_s2    <= 1'b1;
            sda_prev  <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            sda_bit   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the value
            // from before this edge; blocking here would collapse the chain.
            scl_s1    <= bus.scl_i;
            scl_s2    <= scl_s1;
            scl_prev  <= scl_s2;
            sda_s1    <= bus.sda_i;
            sda_s2    <= sda_s1;
            sda_prev  <= sda_s2;
            scl_rise  <= scl_s2 & ~scl_prev;
            scl_fall  <= ~scl_s2 & scl_prev;
            start_det <= scl_s2 & scl_prev & sda_prev & ~sda_s2;
            stop_det  <= scl_s2 & scl_prev & ~sda_prev & sda_s2;
            sda_bit   <= sda_s2;
        end
    end

    assign byte_in = {shift[6:0], sda_bit};
    assign ptr_inc = ptr + 4'd1;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_n   = state;
        shift_n   = shift;
        bit_cnt_n = bit_cnt;
        ptr_n     = ptr;
        oen_n     = oen_q;
        busy_n    = busy_q;
        bus_we    = 1'b0;
        wr_stb_n  = 1'b0;
        wr_adr_n  = wr_adr;
        wr_data_n = wr_data;

        if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = 4'd0;
            oen_n     = 1'b1;
            busy_n    = 1'b1;
        end else if (stop_det) begin
            state_n = IDLE;
            oen_n   = 1'b1;
            busy_n  = 1'b0;
        end else begin
            unique case (state)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shift_n   = byte_in;
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_n = 4'd0;
                            if (state == ADDR) begin
                                state_n = (byte_in[7:1] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
                            end else if (state == PTR) begin
                                ptr_n   = byte_in[3:0];
                                state_n = PTR_ACK;
                            end else begin
                                bus_we    = 1'b1;
                                wr_stb_n  = 1'b1;
                                wr_adr_n  = ptr;
                                wr_data_n = byte_in;
                                ptr_n     = ptr_inc;
                                state_n   = WDATA_ACK;
                            end
                        end
                    end
                end
                // First falling edge starts the ACK pulse, the second ends it.
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd0) begin
                            oen_n     = 1'b0;
                            bit_cnt_n = 4'd1;
                        end else begin
                            oen_n     = 1'b1;
                            bit_cnt_n = 4'd0;
                            state_n   = (state == ADDR_ACK) ? PTR : WDATA;
                            // shift[0] still holds the R/W bit of the address byte.
                            if (state == ADDR_ACK && shift[0]) begin
                                oen_n     = regfile[ptr][7];
                                shift_n   = {regfile[ptr][6:0], 1'b0};
                                bit_cnt_n = 4'd1;
                                state_n   = RDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            oen_n     = 1'b1;
                            bit_cnt_n = 4'd0;
                            state_n   = RACK;
                        end else begin
                            oen_n     = shift[7];
                            shift_n   = {shift[6:0], 1'b0};
                            bit_cnt_n = bit_cnt + 4'd1;
                        end
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        if (!sda_bit) begin
                            ptr_n     = ptr_inc;
                            shift_n   = regfile[ptr_inc];
                            bit_cnt_n = 4'd0;
                            state_n   = RDATA;
                        end else begin
                            state_n = IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift   <= 8'h00;
            bit_cnt <= 4'd0;
            ptr     <= 4'd0;
            oen_q   <= 1'b1;
            busy_q  <= 1'b0;
            wr_stb  <= 1'b0;
            wr_adr  <= 4'd0;
            wr_data <= 8'h00;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            bit_cnt <= bit_cnt_n;
            ptr     <= ptr_n;
            oen_q   <= oen_n;
            busy_q  <= busy_n;
            wr_stb  <= wr_stb_n;
            wr_adr  <= wr_adr_n;
            wr_data <= wr_data_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file is small and must read back zero after
            // reset, so it lives in flops with a reset rather than a RAM.
            for (int i = 0; i < 16; i++) regfile[i] <= 8'h00;
            loc_rdata <= 8'h00;
        end else begin
            loc_rdata <= regfile[loc_adr];
            if (loc_we) regfile[loc_adr] <= loc_wdata;
            // Later assignment wins: a bus write overrides a same-register local write.
            if (bus_we) regfile[ptr] <= byte_in;
        end
    end

    assign bus.sda_o     = 1'b0;
    assign bus.sda_oen_n = oen_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_iic_slave.sv
// Directed bench for iic_slave: bit-banged I2C master on an open-drain line,
// register file model, and a wr_stb capture queue.
module tb_iic_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [3:0] loc_adr = 4'd0;
    logic       loc_we = 1'b0;
    logic [7:0] loc_wdata = 8'h00;
    logic [7:0] loc_rdata;
    logic       wr_stb;
    logic [3:0] wr_adr;
    logic [7:0] wr_data;
    logic       busy;

    iic_slave_if bus ();

    assign bus.scl_i = scl_m;
    assign bus.sda_i = sda_m & (bus.sda_oen_n | bus.sda_o);

    iic_slave #(.SLAVE_ADDR(7'h50)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .loc_adr   (loc_adr),
        .loc_we    (loc_we),
        .loc_wdata (loc_wdata),
        .loc_rdata (loc_rdata),
        .wr_stb    (wr_stb),
        .wr_adr    (wr_adr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          errors  = 0;
    logic [7:0]  exp_rf [16];
    logic [11:0] stb_q [$];
    logic        stb_prev = 1'b0;
    int          stb_wide = 0;
    logic        pulled = 1'b0;

    always @(negedge clk) begin
        if (wr_stb) begin
            stb_q.push_back({wr_adr, wr_data});
            if (stb_prev) stb_wide++;
        end
        stb_prev = wr_stb;
        if (bus.sda_oen_n == 1'b0) pulled = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, input logic col, output logic seen);
        wait_clk(4);
        sda_m = b;
        wait_clk(4);
        scl_m = 1'b1;
        if (col) begin
            wait_clk(3);
            check("stb_early", wr_stb, 1'b0);
            loc_adr = 4'd7; loc_wdata = 8'hC3; loc_we = 1'b1;
            wait_clk(1);
            loc_we = 1'b0;
            check("stb_timing", wr_stb, 1'b1);
        end else begin
            wait_clk(4);
        end
        seen = bus.sda_i;
        wait_clk(4);
        scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic col, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], col && (i == 0), s);
        bit_xfer(1'b1, 1'b0, ack);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(1'b1, 1'b0, d[i]);
        bit_xfer(mack, 1'b0, s);
    endtask

    task automatic do_start;
        if (!scl_m) begin
            wait_clk(4); sda_m = 1'b1;
            wait_clk(4); scl_m = 1'b1;
            wait_clk(4);
        end
        sda_m = 1'b0;
        wait_clk(8);
        scl_m = 1'b0;
    endtask

    task automatic do_stop;
        wait_clk(4); sda_m = 1'b0;
        wait_clk(4); scl_m = 1'b1;
        wait_clk(4); sda_m = 1'b1;
        wait_clk(8);
    endtask

    task automatic loc_write(input logic [3:0] a, input logic [7:0] d);
        loc_adr = a; loc_wdata = d; loc_we = 1'b1;
        wait_clk(1);
        loc_we = 1'b0;
    endtask

    task automatic check_rf;
        for (int i = 0; i < 16; i++) begin
            loc_adr = 4'(i);
            wait_clk(1);
            check($sformatf("rf%0d", i), loc_rdata, exp_rf[i]);
        end
    endtask

    task automatic check_stb(input string tag, input logic [11:0] exp);
        if (stb_q.size() == 0) check(tag, 12'hFFF, exp);
        else check(tag, stb_q.pop_front(), exp);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        for (int i = 0; i < 16; i++) exp_rf[i] = 8'h00;

        // Reset and idle
        wait_clk(3);
        check("rst_oen", bus.sda_oen_n, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_stb", wr_stb, 1'b0);
        rst_n = 1'b1;
        wait_clk(4);
        check_rf();

        // Pointer write and two data bytes
        do_start();
        send_byte(8'hA0, 1'b0, ack); check("w_addr_ack", ack, 1'b0);
        check("w_busy", busy, 1'b1);
        send_byte(8'h03, 1'b0, ack); check("w_ptr_ack", ack, 1'b0);
        send_byte(8'h11, 1'b0, ack); check("w_d0_ack", ack, 1'b0);
        send_byte(8'h22, 1'b0, ack); check("w_d1_ack", ack, 1'b0);
        do_stop();
        check("w_busy_end", busy, 1'b0);
        check_stb("w_stb0", {4'd3, 8'h11});
        check_stb("w_stb1", {4'd4, 8'h22});
        exp_rf[3] = 8'h11; exp_rf[4] = 8'h22;

        // Pointer wrap 15 -> 0
        do_start();
        send_byte(8'hA0, 1'b0, ack); check("wrap_addr_ack", ack, 1'b0);
        send_byte(8'h0F, 1'b0, ack); check("wrap_ptr_ack", ack, 1'b0);
        send_byte(8'hAA, 1'b0, ack); check("wrap_d0_ack", ack, 1'b0);
        send_byte(8'hBB, 1'b0, ack); check("wrap_d1_ack", ack, 1'b0);
        do_stop();
        check_stb("wrap_stb0", {4'd15, 8'hAA});
        check_stb("wrap_stb1", {4'd0, 8'hBB});
        exp_rf[15] = 8'hAA; exp_rf[0] = 8'hBB;

        // Local write becomes visible to the bus read below
        loc_write(4'd5, 8'h96);
        exp_rf[5] = 8'h96;
        check_rf();

        // Repeated-start read with auto-increment
        do_start();
        send_byte(8'hA0, 1'b0, ack); check("r_addr_ack", ack, 1'b0);
        send_byte(8'h03, 1'b0, ack); check("r_ptr_ack", ack, 1'b0);
        do_start();
        send_byte(8'hA1, 1'b0, ack); check("r_addr1_ack", ack, 1'b0);
        recv_byte(1'b0, d); check("r_byte0", d, 8'h11);
        recv_byte(1'b0, d); check("r_byte1", d, 8'h22);
        recv_byte(1'b1, d); check("r_byte2", d, 8'h96);
        pulled = 1'b0;
        wait_clk(20);
        check("r_nack_release", pulled, 1'b0);
        do_stop();
        check("r_no_stb", stb_q.size(), 0);

        // Foreign address: ignored until STOP
        pulled = 1'b0;
        do_start();
        send_byte(8'hB0, 1'b0, ack); check("x_addr_nack", ack, 1'b1);
        send_byte(8'h12, 1'b0, ack); check("x_d0_nack", ack, 1'b1);
        send_byte(8'h34, 1'b0, ack); check("x_d1_nack", ack, 1'b1);
        check("x_busy", busy, 1'b1);
        do_stop();
        check("x_busy_end", busy, 1'b0);
        check("x_never_pulled", pulled, 1'b0);
        check("x_no_stb", stb_q.size(), 0);
        check_rf();

        // Bus and local write to reg7 in the same cycle
        do_start();
        send_byte(8'hA0, 1'b0, ack); check("c_addr_ack", ack, 1'b0);
        send_byte(8'h07, 1'b0, ack); check("c_ptr_ack", ack, 1'b0);
        send_byte(8'h5A, 1'b1, ack); check("c_d_ack", ack, 1'b0);
        do_stop();
        check_stb("c_stb", {4'd7, 8'h5A});
        exp_rf[7] = 8'h5A;
        check_rf();
        check("stb_width", stb_wide, 0);

        // Reset while the slave drives a 0 data bit (reg3 = 0x11, MSB 0)
        do_start();
        send_byte(8'hA0, 1'b0, ack);
        send_byte(8'h03, 1'b0, ack);
        do_start();
        send_byte(8'hA1, 1'b0, ack); check("rr_addr_ack", ack, 1'b0);
        wait_clk(6);
        check("rr_driving", bus.sda_oen_n, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rr_async_release", bus.sda_oen_n, 1'b1);
        check("rr_busy", busy, 1'b0);
        scl_m = 1'b1; sda_m = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(5);
        for (int i = 0; i < 16; i++) exp_rf[i] = 8'h00;
        check_rf();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
